// File: rtl/data_pack_if.sv
// -----------------------------------------------------------------------------
// data_pack_if
// Stream bundle around the 7-to-32 packer.
//
// Handshake: a value moves on the input side in any cycle where
// valid_in && ready_out; a word moves on the output side in any cycle where
// valid_out && ready_in. A holder of valid keeps its payload and valid stable
// until the transfer happens. ready may depend combinationally on the other
// side's valid/ready.
//
// Signals:
//   ready_out  packer -> source  room for an input value this cycle
//   valid_in   source -> packer  data_in/sop_in/eop_in are valid
//   data_in    source -> packer  IN_W-bit value, packed LSB-first
//   sop_in     source -> packer  first value of a packet
//   eop_in     source -> packer  last value of a packet
//   valid_out  packer -> sink    data_out/sop_out/eop_out hold a word
//   ready_in   sink -> packer    sink takes the word this cycle
//   data_out   packer -> sink    OUT_W-bit packed word
//   sop_out    packer -> sink    first word of a packet
//   eop_out    packer -> sink    last word of a packet
//   state_dbg  packer -> any     current FSM state, for observation only
//
// Modports: master = packer side, slave = the environment (source + sink).
// -----------------------------------------------------------------------------
interface data_pack_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 32
);
  logic             ready_out;
  logic             valid_in;
  logic [IN_W-1:0]  data_in;
  logic             sop_in;
  logic             eop_in;
  logic             valid_out;
  logic             ready_in;
  logic [OUT_W-1:0] data_out;
  logic             sop_out;
  logic             eop_out;
  logic [1:0]       state_dbg;

  modport master (
    output ready_out, valid_out, data_out, sop_out, eop_out, state_dbg,
    input  valid_in, data_in, sop_in, eop_in, ready_in
  );

  modport slave (
    input  ready_out, valid_out, data_out, sop_out, eop_out, state_dbg,
    output valid_in, data_in, sop_in, eop_in, ready_in
  );
endinterface

// File: rtl/data_pack.sv
// -----------------------------------------------------------------------------
// data_pack
// Packs a framed stream of IN_W-bit values LSB-first into OUT_W-bit words.
// The final word of a packet is zero-padded above the last valid bit. One
// registered output word; a word is presented the cycle after the value that
// completes it is accepted.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   bus        data_pack_if.master (input value stream, output word stream,
//              FSM state for observation)
//   proto_err  sticky framing error flag (only with DATA_PACK_PROTO_ERR_EN)
//
// Build option: define DATA_PACK_PROTO_ERR_EN to add proto_err, set the cycle
// after a non-sop value is accepted while idle or a sop value is accepted
// mid-packet. Framing behaviour does not change either way.
// -----------------------------------------------------------------------------
module data_pack #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 32
) (
  input  logic clk,
  input  logic rst,
  data_pack_if.master bus
`ifdef DATA_PACK_PROTO_ERR_EN
  ,
  output logic proto_err
`endif
);

  localparam int ACC_W  = OUT_W + IN_W - 1;
  localparam int FILL_W = $clog2(OUT_W + IN_W);
  localparam logic [FILL_W-1:0] IN_WF  = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] OUT_WF = FILL_W'(OUT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ACC_W-1:0]  acc, acc_n;
  logic [FILL_W-1:0] fill, fill_n;
  logic              first_word, first_n;

  logic              valid_q, sop_q, eop_q;
  logic [OUT_W-1:0]  data_q;

  // Combinational controls
  logic              ready;
  logic              slot_free;
  logic              do_pack;
  logic [ACC_W-1:0]  base_acc, acc_ins;
  logic [FILL_W-1:0] base_fill, sum_fill;
  logic              base_first;
  logic              load;
  logic [OUT_W-1:0]  ld_data;
  logic              ld_sop, ld_eop;

  assign slot_free = !valid_q || bus.ready_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      fill       <= '0;
      first_word <= 1'b1;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      fill       <= fill_n;
      first_word <= first_n;
    end
  end

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    fill_n     = fill;
    first_n    = first_word;
    ready      = 1'b0;
    do_pack    = 1'b0;
    base_acc   = acc;
    base_fill  = fill;
    base_first = first_word;
    acc_ins    = '0;
    sum_fill   = '0;
    load       = 1'b0;
    ld_data    = '0;
    ld_sop     = 1'b0;
    ld_eop     = 1'b0;

    case (state)
      IDLE: begin
        // Always ready; non-sop values are consumed and dropped. A sop value
        // starts from a clean accumulator regardless of leftovers.
        ready      = 1'b1;
        do_pack    = bus.valid_in && bus.sop_in;
        base_acc   = '0;
        base_fill  = '0;
        base_first = 1'b1;
      end
      PACK: begin
        // Only a value that completes a word needs the output slot.
        ready   = ((fill + IN_WF) < OUT_WF) || slot_free;
        do_pack = bus.valid_in && ready;
      end
      FLUSH: begin
        ready = 1'b0;
        if (slot_free) begin
          // Bits above fill-1 are already zero: acc is cleared on entry to a
          // packet and zero-filled by every right shift.
          load    = 1'b1;
          ld_data = acc[OUT_W-1:0];
          ld_sop  = first_word;
          ld_eop  = 1'b1;
          acc_n   = '0;
          fill_n  = '0;
          first_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (do_pack) begin
      acc_ins                  = base_acc;
      acc_ins[base_fill +: IN_W] = bus.data_in;
      sum_fill                 = base_fill + IN_WF;
      if (sum_fill >= OUT_WF) begin
        load    = 1'b1;
        ld_data = acc_ins[OUT_W-1:0];
        ld_sop  = base_first;
        // eop rides on this word only if nothing is left over for a flush.
        ld_eop  = bus.eop_in && (sum_fill == OUT_WF);
        acc_n   = acc_ins >> OUT_W;
        fill_n  = sum_fill - OUT_WF;
        first_n = 1'b0;
      end else begin
        acc_n   = acc_ins;
        fill_n  = sum_fill;
        first_n = base_first;
      end
      if (bus.eop_in) begin
        state_n = (fill_n != '0) ? FLUSH : IDLE;
      end else begin
        state_n = PACK;
      end
    end
  end

  // Output slot: reload wins over drain, so back-to-back words never bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= ld_data;
      sop_q   <= ld_sop;
      eop_q   <= ld_eop;
    end else if (bus.ready_in) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ready_out = ready;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.sop_out   = sop_q;
  assign bus.eop_out   = eop_q;
  assign bus.state_dbg = state;

`ifdef DATA_PACK_PROTO_ERR_EN
  logic err_set;
  assign err_set = bus.valid_in && ready &&
                   (((state == IDLE) && !bus.sop_in) ||
                    ((state == PACK) &&  bus.sop_in));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      proto_err <= 1'b0;
    end else if (err_set) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_pack.sv
// -----------------------------------------------------------------------------
// tb_data_pack
// Directed bench for data_pack: a driver task pushes framed values, a monitor
// pops an expected-word queue on every output transfer, and a final line
// reports the totals.
// -----------------------------------------------------------------------------
module tb_data_pack;
  localparam int IN_W  = 7;
  localparam int OUT_W = 32;
  localparam int EXP_W = OUT_W + 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_pack_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

`ifdef DATA_PACK_PROTO_ERR_EN
  logic proto_err;
`endif

  data_pack #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DATA_PACK_PROTO_ERR_EN
    ,
    .proto_err (proto_err)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  int stalls;
  int first_stall_idx;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected entry layout: {sop, eop, data}
  function automatic logic [EXP_W-1:0] wexp(input logic s, input logic e,
                                            input logic [OUT_W-1:0] d);
    return {s, e, d};
  endfunction

  // Word k of the ramp packet v_i = i, i = 0..31, packed LSB-first.
  function automatic logic [OUT_W-1:0] ramp_word(input int k);
    logic [32*IN_W-1:0] pk;
    pk = '0;
    for (int i = 0; i < 32; i++) pk[i*IN_W +: IN_W] = 7'(i);
    return pk[k*OUT_W +: OUT_W];
  endfunction

  task automatic push_ramp();
    exp_q.push_back(wexp(1'b1, 1'b0, 32'h4060_8080));
    for (int k = 1; k < 7; k++) exp_q.push_back(wexp(1'b0, k == 6, ramp_word(k)));
  endtask

  // Monitor: a word moves at the next rising edge when valid && ready now.
  always @(negedge clk) begin
    if (rst && bus.valid_out && bus.ready_in) begin
      logic [EXP_W-1:0] got, exp;
      got = {bus.sop_out, bus.eop_out, bus.data_out};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("word", 64'(got), 64'(exp));
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic send(input logic [IN_W-1:0] d, input logic s, input logic e,
                      output int st);
    int n;
    n = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.sop_in   = s;
    bus.eop_in   = e;
    @(negedge clk);
    while (!bus.ready_out && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.ready_out) check("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
    st = n;
  endtask

  // Sends the first n_send values of an n_total-value packet.
  task automatic send_vals(input int n_total, input int n_send,
                           input logic [IN_W-1:0] fixed, input bit ramp);
    int st;
    for (int i = 0; i < n_send; i++) begin
      send(ramp ? 7'(i) : fixed, i == 0, i == n_total - 1, st);
      if (st > 0 && first_stall_idx < 0) first_stall_idx = i;
      stalls += st;
    end
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int st;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
    bus.ready_in = 1'b1;
    stalls = 0;
    first_stall_idx = -1;

    #12;
    check("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check("rst_data_out",  64'(bus.data_out),  64'd0);
    check("rst_sop_out",   64'(bus.sop_out),   64'd0);
    check("rst_eop_out",   64'(bus.eop_out),   64'd0);
    check("rst_ready_out", 64'(bus.ready_out), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 32-value ramp, full-rate sink
    push_ramp();
    stalls = 0;
    send_vals(32, 32, '0, 1'b1);
    check("ramp_stalls", 64'(stalls), 64'd0);
    wait_drain("ramp_drain");

    // 3 x 0x7F -> single padded word
    exp_q.push_back(wexp(1'b1, 1'b1, 32'h001F_FFFF));
    send_vals(3, 3, 7'h7F, 1'b0);
    wait_drain("short_drain");

    // single-value packet then immediate next packet
    exp_q.push_back(wexp(1'b1, 1'b1, 32'h0000_0055));
    exp_q.push_back(wexp(1'b1, 1'b1, 32'h001F_FFFF));
    send(7'h55, 1'b1, 1'b1, st);
    stalls = 0;
    first_stall_idx = -1;
    send_vals(3, 3, 7'h7F, 1'b0);
    check("single_gap_le1", 64'(stalls > 1), 64'd0);
    wait_drain("single_drain");

`ifdef DATA_PACK_PROTO_ERR_EN
    check("proto_err_clean", 64'(proto_err), 64'd0);
`endif

    // pre-sop junk is dropped, then a valid packet
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      send(7'h7F, 1'b0, 1'b0, st);
      stalls += st;
    end
    check("junk_stalls", 64'(stalls), 64'd0);
    exp_q.push_back(wexp(1'b1, 1'b1, 32'h001F_FFFF));
    send_vals(3, 3, 7'h7F, 1'b0);
    wait_drain("junk_drain");
`ifdef DATA_PACK_PROTO_ERR_EN
    check("proto_err_set", 64'(proto_err), 64'd1);
`endif

    // backpressure: sink stalls for 5 cycles once word0 appears
    push_ramp();
    stalls = 0;
    first_stall_idx = -1;
    fork
      send_vals(32, 32, '0, 1'b1);
      begin
        int k;
        k = 0;
        do begin
          @(posedge clk);
          #1;
          k++;
        end while (!bus.valid_out && k < 100);
        check("bp_word0_seen", 64'(bus.valid_out), 64'd1);
        bus.ready_in = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_hold_data", 64'(bus.data_out), 64'h4060_8080);
          check("bp_hold_valid", 64'(bus.valid_out), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.ready_in = 1'b1;
      end
    join
    check("bp_first_stall_idx", 64'(first_stall_idx), 64'd9);
    wait_drain("bp_drain");

    // reset mid-packet after 10 values; word1 is pending in the slot
    exp_q.push_back(wexp(1'b1, 1'b0, 32'h4060_8080));
    send_vals(32, 10, '0, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_valid_out", 64'(bus.valid_out), 64'd0);
    check("midrst_data_out",  64'(bus.data_out),  64'd0);
    check("midrst_queue",     64'(exp_q.size()),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(wexp(1'b1, 1'b1, 32'h001F_FFFF));
    send_vals(3, 3, 7'h7F, 1'b0);
    wait_drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_pack.md
Name: data_pack

Overview:
- Transmit-side packer: accepts a stream of 7-bit values with sop/eop framing and packs them LSB-first into 32-bit words with sop/eop framing.
- Inverse of the 32-to-7 unpacker; feeds 32-bit links that the unpacker later consumes.
- Valid/ready handshake on both sides, single registered output stage, zero-padded final word.

Parameters:
- IN_W, 7, input value width in bits (1..OUT_W-1)
- OUT_W, 32, output word width in bits

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- ready_out  output  1  room to accept an input value this cycle
- valid_in  input  1  value transferred when valid_in && ready_out
- data_in  input  IN_W  input value, packed LSB-first
- sop_in  input  1  first value of a packet
- eop_in  input  1  last value of a packet
- valid_out  output  1  data_out holds a word
- ready_in  input  1  downstream accepts the word when valid_out && ready_in
- data_out  output  OUT_W  packed word
- sop_out  output  1  first word of a packet, qualified by valid_out
- eop_out  output  1  last word of a packet, qualified by valid_out

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, accumulator=0, fill=0, first_word=1.
  - valid_out=0, data_out=0, sop_out=0, eop_out=0, immediately and held until rst=1.
  - Reset mid-packet discards all residual bits and any pending word.
- Datapath:
  - Accumulator acc[OUT_W+IN_W-2:0]; fill counter 0..OUT_W+IN_W-1.
  - An accepted value is written at acc[fill +: IN_W]; fill += IN_W.
  - If new fill >= OUT_W: acc[OUT_W-1:0] is loaded into the output register, acc shifts right by OUT_W, fill -= OUT_W.
- Output register: one word deep.
  - Loaded at most once per cycle.
  - data_out/sop_out/eop_out stay stable while valid_out && !ready_in.
  - valid_out clears on transfer unless reloaded in the same cycle.
- Latency: a word appears on valid_out the cycle after the value that completes it is accepted.
- States:
  - IDLE:
    - ready_out=1.
    - Values with sop_in=0 are discarded.
    - A value with sop_in=1 is packed, first_word=1 -> PACK.
    - If eop_in is also 1, handled as the PACK eop case in the same cycle.
  - PACK:
    - ready_out = (fill+IN_W < OUT_W) || !valid_out || ready_in. Combinational path from ready_in to ready_out is allowed.
    - sop_in on a mid-packet value is ignored; the value is packed as ordinary data.
    - Value accepted with eop_in=1: emit a completed word if any. If residual fill>0 -> FLUSH; else the emitted word carries eop_out=1 -> IDLE.
  - FLUSH:
    - ready_out=0.
    - When the output slot is free (!valid_out || ready_in), load residual zero-padded above bit fill-1 with eop_out=1.
    - Clear acc, fill and first_word -> IDLE.
- sop_out=1 on the first word loaded after the packet's sop value (first_word), then first_word clears.
- A single-word packet carries sop_out=1 and eop_out=1 together.
- A packet always produces ceil(N*IN_W/OUT_W) words, N = number of values.
- Back-to-back packets: at most one dead input cycle (the FLUSH cycle), and only when the packet length is not a multiple of OUT_W bits.
- With ready_in held at 1, throughput is one input value per cycle with no input stalls.

Optional Feature:
- Macro DATA_PACK_PROTO_ERR_EN.
- Defined: adds output proto_err (1 bit, reset 0, sticky until reset). It sets the cycle after either:
  - a value is accepted in IDLE with sop_in=0, or
  - a value is accepted in PACK with sop_in=1.
- Undefined: no port, no logic; framing behaviour identical either way.

Test Plan:
- 32 values v_i=i, sop on i=0, eop on i=31, ready_in=1:
  - exactly 7 words; word0=0x40608080.
  - sop_out on word0 only, eop_out on word6 only.
  - ready_out never drops.
- 3 values 0x7F (sop first, eop last) -> one word 0x001FFFFF with sop_out=1, eop_out=1; upper 11 bits zero.
- Single value 0x55 with sop_in=eop_in=1 -> word 0x00000055, sop_out=eop_out=1; the next packet's sop accepted within 2 cycles.
- Three values 0x7F with sop_in=0 in IDLE, then the 3-value packet above:
  - pre-sop values produce no output; ready_out stays 1.
  - only 0x001FFFFF emitted.
  - proto_err=1 when DATA_PACK_PROTO_ERR_EN is defined.
- 32-value packet with ready_in=0 for 5 cycles after word0 appears:
  - data_out holds 0x40608080 stable.
  - ready_out drops on the value completing word1.
  - all 7 words delivered in order with no loss or duplication.
- rst=0 asserted mid-packet after 10 values:
  - valid_out=0 immediately.
  - after release, a fresh 3x0x7F packet yields exactly 0x001FFFFF with no stale bits.
